// File: rtl/rijndael_pkg.sv
// rijndael_pkg: shared FSM type and GF(2^8) helpers for the Rijndael inverse cipher
package rijndael_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic int nr(input int nb, input int nk);
    return (nb > nk ? nb : nk) + 6;
  endfunction

  function automatic int shift_ofs(input int nb, input int r);
    return (nb == 8 && r > 1) ? r + 1 : r;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse affine map followed by the field inverse x^254 (an addition chain of 11 products)
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b, x2, x3, x12, x15, x240;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    x2 = gmul(b, b);
    x3 = gmul(x2, b);
    x12 = gmul(gmul(x3, x3), gmul(x3, x3));
    x15 = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction
endpackage

// File: rtl/rijndael_addroundkey.sv
// rijndael_addroundkey: xor the round key into the state
module rijndael_addroundkey #(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_state,
  input  logic [32*NB-1:0] roundkey,
  output logic [32*NB-1:0] out_state
);
  assign out_state = in_state ^ roundkey;
endmodule

// File: rtl/rijndael_inv_mixcolumns.sv
// rijndael_inv_mixcolumns: multiply each column by the {0e,0b,0d,09} circulant
module rijndael_inv_mixcolumns
  import rijndael_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_state,
  output logic [32*NB-1:0] out_state
);
  localparam int W = 32 * NB;
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign out_state[W-1-8*(4*c+r) -: 8] =
        gmul(8'h0e, in_state[W-1-8*(4*c+r) -: 8]) ^
        gmul(8'h0b, in_state[W-1-8*(4*c+(r+1)%4) -: 8]) ^
        gmul(8'h0d, in_state[W-1-8*(4*c+(r+2)%4) -: 8]) ^
        gmul(8'h09, in_state[W-1-8*(4*c+(r+3)%4) -: 8]);
    end
  end
endmodule

// File: rtl/rijndael_inv_round.sv
// rijndael_inv_round: one combinational inverse round; the last round omits InvMixColumns
module rijndael_inv_round #(
  parameter int NB = 4
) (
  input  logic             is_last,
  input  logic [32*NB-1:0] in_state,
  input  logic [32*NB-1:0] roundkey,
  output logic [32*NB-1:0] out_state
);
  logic [32*NB-1:0] sr, sb, ark, mc;
  rijndael_inv_shiftrows #(.NB(NB)) u_sr (.in_state(in_state), .out_state(sr));
  rijndael_inv_subbytes #(.NB(NB)) u_sb (.in_state(sr), .out_state(sb));
  rijndael_addroundkey #(.NB(NB)) u_ark (.in_state(sb), .roundkey(roundkey), .out_state(ark));
  rijndael_inv_mixcolumns #(.NB(NB)) u_mc (.in_state(ark), .out_state(mc));
  assign out_state = is_last ? ark : mc;
endmodule

// File: rtl/rijndael_inv_shiftrows.sv
// rijndael_inv_shiftrows: rotate row r right by its Rijndael offset for the block width
module rijndael_inv_shiftrows
  import rijndael_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_state,
  output logic [32*NB-1:0] out_state
);
  localparam int W = 32 * NB;
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign out_state[W-1-8*(4*c+r) -: 8] =
        in_state[W-1-8*(4*((c + NB - shift_ofs(NB, r)) % NB)+r) -: 8];
    end
  end
endmodule

// File: rtl/rijndael_inv_subbytes.sv
// rijndael_inv_subbytes: inverse S-box applied to every state byte
module rijndael_inv_subbytes
  import rijndael_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_state,
  output logic [32*NB-1:0] out_state
);
  for (genvar b = 0; b < 4 * NB; b++) begin : g_byte
    assign out_state[8*b+7 -: 8] = inv_sbox(in_state[8*b+7 -: 8]);
  end
endmodule

// File: rtl/rijndael_decrypt_iter.sv
// rijndael_decrypt_iter: iterative Rijndael inverse cipher, one inverse round per clock
module rijndael_decrypt_iter
  import rijndael_pkg::*;
#(
  parameter int NB = 4,
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_data,
  output logic [3:0]       rk_idx,
  input  logic [32*NB-1:0] roundkey,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data
);
  localparam int NR = nr(NB, NK);
  localparam int STATESIZE = 32 * NB;
  state_t fsm_q, fsm_d;
  logic [STATESIZE-1:0] data_q, data_d, round_out;
  logic [3:0] cnt_q, cnt_d;
  logic is_last;
  assign is_last = cnt_q == 4'd0;
  rijndael_inv_round #(.NB(NB)) u_round (
    .is_last(is_last), .in_state(data_q), .roundkey(roundkey), .out_state(round_out)
  );
  // FSM, cipher state and round counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
  // next state: initial key add on accept, one inverse round per ROUND cycle
  always_comb begin
    fsm_d = fsm_q == IDLE ? (in_valid ? ROUND : IDLE) :
            fsm_q == ROUND ? (is_last ? DONE : ROUND) :
            (out_ready ? IDLE : DONE);
    data_d = fsm_q == IDLE ? (in_valid ? in_data ^ roundkey : data_q) :
             fsm_q == ROUND ? round_out : data_q;
    cnt_d = fsm_q == IDLE ? (in_valid ? 4'(NR - 1) : cnt_q) :
            fsm_q == ROUND ? cnt_q - 4'd1 : cnt_q;
  end
  // outputs decoded from registered state only
  always_comb begin
    in_ready = fsm_q == IDLE;
    out_valid = fsm_q == DONE;
    out_data = data_q;
    rk_idx = fsm_q == IDLE ? 4'(NR) : fsm_q == ROUND ? cnt_q : 4'd0;
  end
endmodule

// File: doc/rijndael_decrypt_iter.md
RIJNDAEL_DECRYPT_ITER -- requirements
Module: rijndael_decrypt_iter

Interface
REQ-001 SHALL have parameter NB, default 4, meaning the block size in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter NK, default 4, meaning the key size in 32-bit words (4, 6 or 8).
REQ-003 SHALL derive localparam NR = max(NB,NK)+6 and STATESIZE = 32*NB.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  ciphertext offered.
REQ-008 in_ready  output  1  block can accept ciphertext.
REQ-009 in_data  input  STATESIZE  ciphertext, byte order identical to the encrypt round state.
REQ-010 rk_idx  output  4  index of the round key required this cycle.
REQ-011 roundkey  input  STATESIZE  round key rk_idx, driven combinationally by the external key store.
REQ-012 out_valid  output  1  plaintext available.
REQ-013 out_ready  input  1  consumer accepts plaintext.
REQ-014 out_data  output  STATESIZE  plaintext.

Function
REQ-015 SHALL implement the FIPS-197/Rijndael inverse cipher iteratively, one inverse round per clock.
REQ-016 SHALL use FSM states IDLE, ROUND and DONE.
REQ-017 IDLE: in_ready=1, rk_idx=NR; on in_valid&&in_ready: state <= in_data ^ roundkey, counter <= NR-1, go to ROUND.
REQ-018 ROUND: in_ready=0, rk_idx=counter; state <= inverse round(state, roundkey, is_last = (counter==0)); decrement counter.
REQ-019 Inverse round SHALL be InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns; InvMixColumns is skipped when is_last.
REQ-020 ROUND with counter==0 SHALL transition to DONE.
REQ-021 DONE: out_valid=1, out_data=state, rk_idx=0; on out_ready go to IDLE.
REQ-022 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 Latency: acceptance in cycle 0 -> out_valid high in cycle NR+1 (AES-128: cycle 11).
REQ-024 Throughput: at most one block per NR+2 cycles; in_ready SHALL NOT be asserted in DONE, even when out_ready=1.
REQ-025 in_valid and in_data SHALL be ignored outside IDLE.
REQ-026 out_data SHALL equal state in all FSM states; only out_valid qualifies it.
REQ-027 rk_idx SHALL be a registered-state decode with no combinational path from any input.

Reset
REQ-028 rst_n low SHALL force IDLE, counter=0 and state=0 immediately, regardless of clock.
REQ-029 Reset outputs: in_ready=1, out_valid=0, out_data=0, rk_idx=NR.
REQ-030 Reset asserted mid-ROUND or in DONE SHALL discard the block; no out_valid pulse follows reset release.

Structure
REQ-031 rijndael_pkg SHALL hold the state_t enum (IDLE/ROUND/DONE) and a function nr(NB,NK).
REQ-032 Combinational sub-module rijndael_inv_round (ports is_last, in_state, roundkey, out_state) SHALL be instantiated once.
REQ-033 rijndael_inv_round SHALL be built from rijndael_inv_subbytes, rijndael_inv_shiftrows, rijndael_inv_mixcolumns and the existing rijndael_addroundkey.

Verification
REQ-034 NB=NK=4, FIPS-197 key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff in cycle 11; rk_idx sequence 10,9,..,0.
REQ-035 NK=6, key 00..17, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> pt 00112233445566778899aabbccddeeff; NK=8, key 00..1f, ct 8ea2b7ca516745bfeafc49904b496089 -> same pt.
REQ-036 out_ready held low 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; release -> IDLE next cycle.
REQ-037 rst_n pulsed low in ROUND at counter 5 -> in_ready=1, out_valid=0 immediately; a new block then decrypts correctly.
REQ-038 in_valid held high with changing in_data during ROUND -> result matches only the block accepted in IDLE; 100 random blocks match the reference model.
